mem_arbiter: RTL and testbench

Two-master Wishbone arbiter placed directly upstream of `mem_ctrl`: it merges a data port (master 0) and an instruction-fetch port (master 1) onto `mem_ctrl`'s single 16-bit Wishbone slave port, carrying the `byte` qualifier through unchanged. It holds each grant for exactly one transaction, registers all slave-side request signals, and aborts transactions that never receive `ack` using a bus watchdog.

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master Wishbone arbiter in front of mem_ctrl with a bus watchdog.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; fixed m0 priority otherwise.
module mem_arbiter #(
    parameter int TMO_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [19:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic        m0_byte_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    input  logic [19:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic        m1_byte_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic [19:0] s_adr_o,
    output logic [15:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_byte_o,
    output logic        s_stb_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    output logic        tmo_o
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] WDOG_LAST = 8'(TMO_CYCLES - 1);
    state_t      state_q, state_d;
    logic        gnt_q, gnt_d, last_q, last_d, tmo_q, tmo_d;
    logic        stb_q, stb_d, we_q, we_d, byte_q, byte_d;
    logic [19:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d, rsp_dat;
    logic [7:0]  wdog_q, wdog_d;
    logic        busy, abort, done, win, both_win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign both_win = ~last_q;
`else
    assign both_win = 1'b0;
`endif
    assign win      = (m0_stb_i & m1_stb_i) ? both_win : m1_stb_i;
    assign busy     = state_q == BUSY;
    // A real ack in the final watchdog cycle wins over the abort.
    assign abort    = busy & ~s_ack_i & (wdog_q == WDOG_LAST);
    assign done     = busy & (s_ack_i | abort);
    assign rsp_dat  = abort ? 16'hffff : s_dat_i;
    assign m0_ack_o = done & ~gnt_q;
    assign m1_ack_o = done & gnt_q;
    assign m0_dat_o = (busy & ~gnt_q) ? rsp_dat : 16'h0000;
    assign m1_dat_o = (busy & gnt_q) ? rsp_dat : 16'h0000;
    assign s_adr_o  = adr_q;
    assign s_dat_o  = dat_q;
    assign s_we_o   = we_q;
    assign s_byte_o = byte_q;
    assign s_stb_o  = stb_q;
    assign tmo_o    = tmo_q;
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        stb_d   = stb_q;
        we_d    = we_q;
        byte_d  = byte_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        wdog_d  = wdog_q;
        if (!busy) begin
            if (m0_stb_i | m1_stb_i) begin
                state_d = BUSY;
                gnt_d   = win;
                adr_d   = win ? m1_adr_i : m0_adr_i;
                dat_d   = win ? m1_dat_i : m0_dat_i;
                we_d    = win ? m1_we_i : m0_we_i;
                byte_d  = win ? m1_byte_i : m0_byte_i;
                stb_d   = 1'b1;
                wdog_d  = 8'd0;
            end
        end else if (done) begin
            state_d = IDLE;
            stb_d   = 1'b0;
            last_d  = gnt_q;
            tmo_d   = tmo_q | abort;
        end else begin
            wdog_d = wdog_q + 8'd1;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            tmo_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            adr_q   <= 20'h0;
            dat_q   <= 16'h0;
            wdog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            wdog_q  <= wdog_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with a short watchdog (TMO_CYCLES=4).
module tb_mem_arbiter;
    logic        clk_i = 1'b0, rst_i;
    logic [19:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_we_i, m1_we_i, m0_byte_i, m1_byte_i, m0_stb_i, m1_stb_i;
    logic        m0_ack_o, m1_ack_o, s_we_o, s_byte_o, s_stb_o, s_ack_i, tmo_o;
    int          checks = 0, failures = 0;
    logic        exp_g;

    mem_arbiter #(.TMO_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_byte_i(m0_byte_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_byte_i(m1_byte_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_byte_o(s_byte_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .tmo_o(tmo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        {m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, s_dat_i} = '0;
        {m0_we_i, m1_we_i, m0_byte_i, m1_byte_i, m0_stb_i, m1_stb_i, s_ack_i} = '0;
        rst_i = 1'b1;
        #3;
        chk("rst_stb", s_stb_o, 0);
        chk("rst_we", s_we_o, 0);
        chk("rst_byte", s_byte_o, 0);
        chk("rst_adr", s_adr_o, 0);
        chk("rst_dat", s_dat_o, 0);
        chk("rst_tmo", tmo_o, 0);
        chk("rst_acks", {m0_ack_o, m1_ack_o}, 0);
        chk("rst_mdat", {m0_dat_o, m1_dat_o}, 0);
        cyc;
        rst_i = 1'b0;
        // m0 word read, slave acks in second BUSY cycle
        m0_adr_i = 20'h00008;
        m0_stb_i = 1'b1;
        #1;
        chk("t1_pre_stb", s_stb_o, 0);
        cyc;
        chk("t1_stb", s_stb_o, 1);
        chk("t1_adr", s_adr_o, 20'h00008);
        chk("t1_we", s_we_o, 0);
        chk("t1_no_ack", m0_ack_o, 0);
        cyc;
        s_dat_i = 16'h0a0b;
        s_ack_i = 1'b1;
        #1;
        chk("t1_ack", m0_ack_o, 1);
        chk("t1_dat", m0_dat_o, 16'h0a0b);
        chk("t1_m1_ack", m1_ack_o, 0);
        chk("t1_m1_dat", m1_dat_o, 0);
        cyc;
        m0_stb_i = 1'b0;
        s_ack_i = 1'b0;
        #1;
        chk("t1_stb_drop", s_stb_o, 0);
        chk("t1_ack_drop", m0_ack_o, 0);
        // m1 byte write
        m1_adr_i = 20'h00019;
        m1_dat_i = 16'h008c;
        m1_we_i = 1'b1;
        m1_byte_i = 1'b1;
        m1_stb_i = 1'b1;
        cyc;
        chk("t2_adr", s_adr_o, 20'h00019);
        chk("t2_byte", s_byte_o, 1);
        chk("t2_we", s_we_o, 1);
        chk("t2_dat", s_dat_o, 16'h008c);
        chk("t2_stb", s_stb_o, 1);
        s_dat_i = 16'h0000;
        s_ack_i = 1'b1;
        #1;
        chk("t2_ack", m1_ack_o, 1);
        chk("t2_m0_ack", m0_ack_o, 0);
        cyc;
        m1_stb_i = 1'b0;
        s_ack_i = 1'b0;
        #1;
        chk("t2_ack_drop", m1_ack_o, 0);
        chk("t2_stb_drop", s_stb_o, 0);
        // continuous contention, last served was m1
        m1_we_i = 1'b0;
        m1_byte_i = 1'b0;
        m0_adr_i = 20'h00100;
        m1_adr_i = 20'h00200;
        m0_stb_i = 1'b1;
        m1_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2) == 1;
`else
            exp_g = 1'b0;
`endif
            cyc;
            chk("t3_adr", s_adr_o, exp_g ? 20'h00200 : 20'h00100);
            s_ack_i = 1'b1;
            #1;
            chk("t3_m1_ack", m1_ack_o, exp_g);
            chk("t3_m0_ack", m0_ack_o, !exp_g);
            cyc;
            s_ack_i = 1'b0;
            #1;
            chk("t3_idle", s_stb_o, 0);
        end
        m0_stb_i = 1'b0;
        m1_stb_i = 1'b0;
        // watchdog abort on 4th BUSY cycle
        cyc;
        m0_adr_i = 20'h00040;
        m0_stb_i = 1'b1;
        cyc;
        for (int k = 1; k < 4; k++) begin
            chk("t4_wait_ack", m0_ack_o, 0);
            cyc;
        end
        chk("t4_abort_ack", m0_ack_o, 1);
        chk("t4_abort_dat", m0_dat_o, 16'hffff);
        chk("t4_tmo_pre", tmo_o, 0);
        cyc;
        m0_stb_i = 1'b0;
        #1;
        chk("t4_tmo", tmo_o, 1);
        chk("t4_stb", s_stb_o, 0);
        chk("t4_ack_drop", m0_ack_o, 0);
        m1_stb_i = 1'b1;
        cyc;
        s_ack_i = 1'b1;
        #1;
        chk("t4_norm_ack", m1_ack_o, 1);
        cyc;
        m1_stb_i = 1'b0;
        s_ack_i = 1'b0;
        #1;
        chk("t4_tmo_sticky", tmo_o, 1);
        // asynchronous reset mid-transaction
        m0_adr_i = 20'h00055;
        m0_we_i = 1'b1;
        m0_stb_i = 1'b1;
        cyc;
        chk("t5_busy", s_stb_o, 1);
        #2;
        rst_i = 1'b1;
        s_ack_i = 1'b1;
        #1;
        chk("t5_stb", s_stb_o, 0);
        chk("t5_we", s_we_o, 0);
        chk("t5_adr", s_adr_o, 0);
        chk("t5_tmo", tmo_o, 0);
        chk("t5_ack", m0_ack_o, 0);
        cyc;
        rst_i = 1'b0;
        s_ack_i = 1'b0;
        m0_we_i = 1'b0;
        m1_stb_i = 1'b1;
        cyc;
        chk("t5_first_gnt", s_adr_o, 20'h00055);
        cyc;
        cyc;
        cyc;
        s_dat_i = 16'h1234;
        s_ack_i = 1'b1;
        #1;
        chk("t5_edge_ack", m0_ack_o, 1);
        chk("t5_edge_dat", m0_dat_o, 16'h1234);
        cyc;
        m0_stb_i = 1'b0;
        m1_stb_i = 1'b0;
        s_ack_i = 1'b0;
        #1;
        chk("t5_edge_tmo", tmo_o, 0);
        // stray ack while idle
        s_dat_i = 16'hbeef;
        s_ack_i = 1'b1;
        #1;
        chk("t6_acks", {m0_ack_o, m1_ack_o}, 0);
        chk("t6_dat", m0_dat_o, 0);
        cyc;
        chk("t6_stb", s_stb_o, 0);
        s_ack_i = 1'b0;
        m1_stb_i = 1'b1;
        cyc;
        chk("t6_grant", s_stb_o, 1);
        chk("t6_adr", s_adr_o, 20'h00200);
        s_ack_i = 1'b1;
        cyc;
        m1_stb_i = 1'b0;
        s_ack_i = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
